// File: rtl/carp_loader_pkg.sv
// Shared types and constants for the CARP/EEL program loader.
// Frame layout: MAGIC, LEN_HI, LEN_LO, N x 4 data bytes (big-endian words), CHK.
package carp_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  localparam logic [7:0] LOADER_MAGIC_DEFAULT = 8'hA5;
  localparam int         HDR_LEN              = 3;
  localparam int         BYTES_PER_WORD       = 4;

endpackage

// File: rtl/carp_loader_word_pack.sv
// Packs big-endian bytes into 32-bit words; word_valid pulses for one cycle
// after the 4th byte of each word. word_last flags that the current byte completes a word.
module carp_loader_word_pack
  import carp_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] shift_q;
  logic [1:0]  byte_cnt;

  assign word_last = (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_cnt <= '0;
        shift_q  <= '0;
      end else if (byte_valid) begin
        shift_q  <= {shift_q[15:0], byte_data};
        byte_cnt <= byte_cnt + 2'd1;
        if (word_last) begin
          word_valid <= 1'b1;
          word_data  <= {shift_q, byte_data};
        end
      end
    end
  end

endmodule

// File: rtl/carp_prog_loader.sv
// Framed byte-stream program loader: writes words to program memory from
// address 0 and holds the core in reset until a frame passes its XOR checksum.
module carp_prog_loader
  import carp_loader_pkg::*;
#(
  parameter int         ADDR_W = 14,
  parameter logic [7:0] MAGIC  = LOADER_MAGIC_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              PM_WE,
  output logic [ADDR_W-1:0] PM_ADDR,
  output logic [31:0]       PM_WDATA,
  output logic              CPU_RST,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR,
  output loader_state_t     dbg_state
);

  // Handshake: a byte transfers on a rising edge where RX_VALID && RX_READY;
  // RX_READY stays high from the first edge after reset, the loader never stalls.

  loader_state_t     state;
  logic [7:0]        len_hi;
  logic [15:0]       len_q;
  logic [16:0]       word_cnt;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        xor_q;

  logic        rx_fire;
  logic        frame_start;
  logic        data_byte;
  logic        word_last;
  logic [15:0] len_n;
  logic        len_too_big;

  assign rx_fire     = RX_VALID && RX_READY;
  assign frame_start = rx_fire && (RX_DATA == MAGIC) &&
                       (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign data_byte   = rx_fire && (state == ST_DATA);
  assign len_n       = {len_hi, RX_DATA};
  assign len_too_big = ({16'd0, len_n} > (32'd1 << ADDR_W));
  assign dbg_state   = state;

  carp_loader_word_pack u_pack (
    .clk        (CLK),
    .rst_n      (RST_N),
    .clear      (frame_start),
    .byte_valid (data_byte),
    .byte_data  (RX_DATA),
    .word_last  (word_last),
    .word_valid (PM_WE),
    .word_data  (PM_WDATA)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      RX_READY  <= 1'b0;
      PM_ADDR   <= '0;
      CPU_RST   <= 1'b1;
      LOAD_DONE <= 1'b0;
      LOAD_ERR  <= 1'b0;
      len_hi    <= '0;
      len_q     <= '0;
      word_cnt  <= '0;
      waddr     <= '0;
      xor_q     <= '0;
    end else begin
      RX_READY <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // Non-magic bytes are dropped without touching state or flags.
          if (frame_start) begin
            state     <= ST_LEN_HI;
            xor_q     <= '0;
            word_cnt  <= '0;
            waddr     <= '0;
            CPU_RST   <= 1'b1;
            LOAD_DONE <= 1'b0;
            LOAD_ERR  <= 1'b0;
          end
        end
        ST_LEN_HI: begin
          if (rx_fire) begin
            len_hi <= RX_DATA;
            xor_q  <= xor_q ^ RX_DATA;
            state  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (rx_fire) begin
            len_q <= len_n;
            xor_q <= xor_q ^ RX_DATA;
            if (len_n == 16'd0) begin
              state <= ST_CHECK;
            end else if (len_too_big) begin
              state    <= ST_ERR;
              LOAD_ERR <= 1'b1;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rx_fire) begin
            xor_q <= xor_q ^ RX_DATA;
            if (word_last) begin
              // PM_ADDR lines up with the write strobe raised by the packer.
              PM_ADDR  <= waddr;
              waddr    <= waddr + 1'b1;
              word_cnt <= word_cnt + 17'd1;
              if (word_cnt + 17'd1 == {1'b0, len_q}) state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (rx_fire) begin
            if (RX_DATA == xor_q) begin
              state     <= ST_DONE;
              LOAD_DONE <= 1'b1;
              CPU_RST   <= 1'b0;
            end else begin
              state    <= ST_ERR;
              LOAD_ERR <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carp_prog_loader.sv
// Directed bench for carp_prog_loader: known frames with hand-computed checksums,
// write monitor against an expected queue, flag checks on the CHK edge.
module tb_carp_prog_loader;
  import carp_loader_pkg::*;

  localparam int ADDR_W = 14;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [31:0]       pm_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;
  loader_state_t     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  carp_prog_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .RX_DATA   (rx_data),
    .RX_VALID  (rx_valid),
    .RX_READY  (rx_ready),
    .PM_WE     (pm_we),
    .PM_ADDR   (pm_addr),
    .PM_WDATA  (pm_wdata),
    .CPU_RST   (cpu_rst),
    .LOAD_DONE (load_done),
    .LOAD_ERR  (load_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input bit gaps);
    foreach (bytes[i]) send_byte(bytes[i], gaps);
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_q.push_back(d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
    check({tag, "_pm_we"},     32'(pm_we),     32'd0);
    check({tag, "_pm_addr"},   32'(pm_addr),   32'd0);
    check({tag, "_pm_wdata"},  pm_wdata,       32'd0);
    check({tag, "_cpu_rst"},   32'(cpu_rst),   32'd1);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_err"},  32'(load_err),  32'd0);
    check({tag, "_state"},     32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic check_flags(input string tag, input logic done, input logic err, input logic crst);
    check({tag, "_load_done"}, 32'(load_done), 32'(done));
    check({tag, "_load_err"},  32'(load_err),  32'(err));
    check({tag, "_cpu_rst"},   32'(cpu_rst),   32'(crst));
  endtask

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("pm_we_unexpected", 32'd1, 32'd0);
      end else begin
        check("pm_addr", 32'(pm_addr), exp_addr_q.pop_front());
        check("pm_wdata", pm_wdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] fr[$];
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 32'(rx_ready), 32'd1);

    // one-word frame, good checksum
    expect_write(32'd0, 32'hDEADBEEF);
    send_byte(8'hA5, 1'b0);
    check("magic_cpu_rst", 32'(cpu_rst), 32'd1);
    fr = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(fr, 1'b0);
    check("one_word_before_chk_done", 32'(load_done), 32'd0);
    send_byte(8'h23, 1'b0);
    check_flags("one_word", 1'b1, 1'b0, 1'b0);
    check("one_word_pending", 32'(exp_q.size()), 32'd0);

    // stray byte in DONE is discarded
    send_byte(8'h11, 1'b0);
    check_flags("done_stray", 1'b1, 1'b0, 1'b0);

    // reload from DONE: two words, random gaps
    expect_write(32'd0, 32'h00000013);
    expect_write(32'd1, 32'h12345678);
    send_byte(8'hA5, 1'b1);
    check_flags("reload_magic", 1'b0, 1'b0, 1'b1);
    fr = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h12, 8'h34, 8'h56, 8'h78};
    send_frame(fr, 1'b1);
    send_byte(8'h19, 1'b1);
    check_flags("two_word", 1'b1, 1'b0, 1'b0);
    check("two_word_pending", 32'(exp_q.size()), 32'd0);

    // bad checksum: write still lands, error flagged
    expect_write(32'd0, 32'hDEADBEEF);
    fr = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h24};
    send_frame(fr, 1'b0);
    check_flags("bad_chk", 1'b0, 1'b1, 1'b1);
    check("bad_chk_pending", 32'(exp_q.size()), 32'd0);

    // garbage ignored in ERR, then empty frame
    fr = '{8'h00, 8'hFF, 8'h5A};
    send_frame(fr, 1'b0);
    check_flags("garbage", 1'b0, 1'b1, 1'b1);
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(fr, 1'b0);
    check_flags("empty_frame", 1'b1, 1'b0, 1'b0);

    // async reset mid-frame after two data bytes
    fr = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD};
    send_frame(fr, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    expect_write(32'd0, 32'h12345678);
    fr = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    send_frame(fr, 1'b0);
    check_flags("after_reset", 1'b1, 1'b0, 1'b0);
    check("after_reset_pending", 32'(exp_q.size()), 32'd0);

    // word count above 2^ADDR_W (0x4001 > 0x4000)
    fr = '{8'hA5, 8'h40, 8'h01};
    send_frame(fr, 1'b0);
    check_flags("len_too_big", 1'b0, 1'b1, 1'b1);
    check("len_too_big_state", 32'(dbg_state), 32'(ST_ERR));

    // exact limit 0x4000 is accepted into DATA
    fr = '{8'hA5, 8'h40, 8'h00};
    send_frame(fr, 1'b0);
    check("len_limit_state", 32'(dbg_state), 32'(ST_DATA));
    check_flags("len_limit", 1'b0, 1'b0, 1'b1);

    repeat (4) @(posedge clk);
    #1;
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
